sigsource_sched: RTL and testbench

- Time-multiplexing scheduler that drives the correlator signal-source stage.
- Accepts one antenna IQ sample word per handshake from the capture front-end.
- Replays each word for TRATE consecutive cycles while stepping taddr_o 0..TRATE-1, so the downstream MUX stage visits every A/B correlator pair.
- Frames accumulation blocks of BLOCK_N samples with first_o/last_o markers, and reports buffer underrun.

---
 rtl/sigsource_sched.sv | 193 +++++++++++++++++++
 tb/tb_sigsource_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sigsource_sched.sv
// sigsource_sched: replays each antenna IQ word for TRATE cycles
// while stepping the time-slot address, framed into accumulation blocks.
module sigsource_sched #(
    parameter int WIDTH   = 32,
    parameter int TRATE   = 30,
    parameter int TBITS   = 5,
    parameter int BLOCK_N = 4096,
    parameter int CBITS   = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_idata_i,
    input  logic [WIDTH-1:0] s_qdata_i,
    output logic             valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic [TBITS-1:0] taddr_o,
    output logic [WIDTH-1:0] idata_o,
    output logic [WIDTH-1:0] qdata_o,
    output logic             busy_o,
    output logic             underrun_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    localparam logic [TBITS-1:0] TLAST = TBITS'(TRATE - 1);
    localparam logic [CBITS-1:0] CLAST = CBITS'(BLOCK_N - 1);

    state_e           state_q, state_d;
    logic [TBITS-1:0] taddr_q, taddr_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] curi_q, curi_d;
    logic [WIDTH-1:0] curq_q, curq_d;
    logic [WIDTH-1:0] nxti_q, nxti_d;
    logic [WIDTH-1:0] nxtq_q, nxtq_d;
    logic             nxt_full_q, nxt_full_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             under_q, under_d;

    logic             acc;
    logic             avail;
    logic             load;
    logic             wrap;
    logic             blk_end;
    logic [WIDTH-1:0] src_i;
    logic [WIDTH-1:0] src_q;

    assign acc     = s_valid_i & ready_q;
    assign avail   = nxt_full_q | acc;
    assign src_i   = nxt_full_q ? nxti_q : s_idata_i;
    assign src_q   = nxt_full_q ? nxtq_q : s_qdata_i;
    assign wrap    = (taddr_q == TLAST);
    assign blk_end = wrap && (cnt_q == CLAST);

    // Sequencing, buffer movement and registered-output next state.
    // Ready is widened at a mid-block wrap since CUR is released there.
    always_comb begin
        state_d    = state_q;
        taddr_d    = taddr_q;
        cnt_d      = cnt_q;
        curi_d     = curi_q;
        curq_d     = curq_q;
        nxti_d     = nxti_q;
        nxtq_d     = nxtq_q;
        nxt_full_d = nxt_full_q;
        under_d    = under_q;
        load       = 1'b0;
        valid_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en_i && avail) begin
                    load    = 1'b1;
                    state_d = RUN;
                    taddr_d = '0;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                if (!wrap) begin
                    taddr_d = taddr_q + TBITS'(1);
                    valid_d = 1'b1;
                end else if (blk_end) begin
                    taddr_d = '0;
                    cnt_d   = '0;
                    if (en_i && avail) begin
                        load    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    taddr_d = '0;
                    cnt_d   = cnt_q + CBITS'(1);
                    if (avail) begin
                        load    = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        state_d = STALL;
                        under_d = 1'b1;
                    end
                end
            end
            STALL: begin
                if (avail) begin
                    load    = 1'b1;
                    state_d = RUN;
                    valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            curi_d     = src_i;
            curq_d     = src_q;
            nxt_full_d = nxt_full_q & acc;
            if (nxt_full_q && acc) begin
                nxti_d = s_idata_i;
                nxtq_d = s_qdata_i;
            end
        end else if (acc) begin
            nxti_d     = s_idata_i;
            nxtq_d     = s_qdata_i;
            nxt_full_d = 1'b1;
        end

        first_d = valid_d && (taddr_d == '0) && (cnt_d == '0);
        last_d  = valid_d && (taddr_d == TLAST) && (cnt_d == CLAST);
        busy_d  = (state_d != IDLE);
        ready_d = !nxt_full_d ||
                  ((state_d == RUN) && (taddr_d == TLAST) &&
                   (cnt_d != CLAST));
    end

    // State, buffer and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            taddr_q    <= '0;
            cnt_q      <= '0;
            curi_q     <= '0;
            curq_q     <= '0;
            nxti_q     <= '0;
            nxtq_q     <= '0;
            nxt_full_q <= 1'b0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            under_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            taddr_q    <= taddr_d;
            cnt_q      <= cnt_d;
            curi_q     <= curi_d;
            curq_q     <= curq_d;
            nxti_q     <= nxti_d;
            nxtq_q     <= nxtq_d;
            nxt_full_q <= nxt_full_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            first_q    <= first_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            under_q    <= under_d;
        end
    end

    assign s_ready_o  = ready_q;
    assign valid_o    = valid_q;
    assign first_o    = first_q;
    assign last_o     = last_q;
    assign taddr_o    = taddr_q;
    assign idata_o    = curi_q;
    assign qdata_o    = curq_q;
    assign busy_o     = busy_q;
    assign underrun_o = under_q;

endmodule

// File: tb/tb_sigsource_sched.sv
// tb_sigsource_sched: directed vector tables plus hand sequences
// against a BLOCK_N=2 and a BLOCK_N=3 instance, TRATE=4.
module tb_sigsource_sched;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       en_i = 1'b0;
    logic       s_valid_i = 1'b0;
    logic [7:0] s_idata_i = '0;
    logic [7:0] s_qdata_i = '0;

    logic       a_ready, a_valid, a_first, a_last, a_busy, a_under;
    logic [1:0] a_taddr;
    logic [7:0] a_idata, a_qdata;
    logic       b_ready, b_valid, b_first, b_last, b_busy, b_under;
    logic [1:0] b_taddr;
    logic [7:0] b_idata, b_qdata;

    always #5 clock = ~clock;

    sigsource_sched #(
        .WIDTH(8), .TRATE(4), .TBITS(2), .BLOCK_N(2), .CBITS(1)
    ) u_a (
        .clock(clock), .reset_n(reset_n), .en_i(en_i),
        .s_valid_i(s_valid_i), .s_ready_o(a_ready),
        .s_idata_i(s_idata_i), .s_qdata_i(s_qdata_i),
        .valid_o(a_valid), .first_o(a_first), .last_o(a_last),
        .taddr_o(a_taddr), .idata_o(a_idata), .qdata_o(a_qdata),
        .busy_o(a_busy), .underrun_o(a_under)
    );

    sigsource_sched #(
        .WIDTH(8), .TRATE(4), .TBITS(2), .BLOCK_N(3), .CBITS(2)
    ) u_b (
        .clock(clock), .reset_n(reset_n), .en_i(en_i),
        .s_valid_i(s_valid_i), .s_ready_o(b_ready),
        .s_idata_i(s_idata_i), .s_qdata_i(s_qdata_i),
        .valid_o(b_valid), .first_o(b_first), .last_o(b_last),
        .taddr_o(b_taddr), .idata_o(b_idata), .qdata_o(b_qdata),
        .busy_o(b_busy), .underrun_o(b_under)
    );

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       sv;
        logic [7:0] d;
        logic       v;
        logic       f;
        logic       l;
        logic [1:0] ta;
        logic [7:0] od;
        logic       busy;
        logic       rdy;
        logic       und;
    } vec_t;

    vec_t tab[$];
    int   checks = 0;
    int   errors = 0;
    logic hs;

    function automatic vec_t mk(
        logic rst, logic en, logic sv, logic [7:0] d,
        logic v, logic f, logic l, logic [1:0] ta, logic [7:0] od,
        logic busy, logic rdy, logic und);
        vec_t r;
        r.rst = rst; r.en = en; r.sv = sv; r.d = d;
        r.v = v; r.f = f; r.l = l; r.ta = ta; r.od = od;
        r.busy = busy; r.rdy = rdy; r.und = und;
        return r;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic en, logic sv, logic [7:0] d);
        @(negedge clock);
        reset_n   = rst;
        en_i      = en;
        s_valid_i = sv;
        s_idata_i = d;
        s_qdata_i = ~d;
        hs = sv && a_ready;
        @(posedge clock);
        #1;
    endtask

    task automatic check_row(string n, int i, vec_t e, logic sel_b);
        logic       v, f, l, bz, r, u;
        logic [1:0] t;
        logic [7:0] id, qd, ei, eq;
        logic       m;
        v  = sel_b ? b_valid : a_valid;
        f  = sel_b ? b_first : a_first;
        l  = sel_b ? b_last  : a_last;
        t  = sel_b ? b_taddr : a_taddr;
        id = sel_b ? b_idata : a_idata;
        qd = sel_b ? b_qdata : a_qdata;
        bz = sel_b ? b_busy  : a_busy;
        r  = sel_b ? b_ready : a_ready;
        u  = sel_b ? b_under : a_under;
        m  = e.v || !e.rst;
        ei = m ? e.od : 8'h00;
        eq = e.v ? ~e.od : 8'h00;
        if (!m) begin
            id = 8'h00;
            qd = 8'h00;
        end
        checks++;
        if ({v, f, l, t, id, qd, bz, r, u} !==
            {e.v, e.f, e.l, e.ta, ei, eq, e.busy, e.rdy, e.und}) begin
            errors++;
            $display("FAIL %s row %0d: got v%b f%b l%b t%0d i%h q%h b%b r%b u%b want v%b f%b l%b t%0d i%h q%h b%b r%b u%b",
                     n, i, v, f, l, t, id, qd, bz, r, u,
                     e.v, e.f, e.l, e.ta, ei, eq, e.busy, e.rdy, e.und);
        end
    endtask

    task automatic run_tab(string n, logic sel_b);
        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i].rst, tab[i].en, tab[i].sv, tab[i].d);
            check_row(n, i, tab[i], sel_b);
        end
        tab.delete();
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] w[3];
        logic [7:0] seq[$];
        int         acc_cyc[$];
        int         idx;

        // Reset state on both instances.
        tab.push_back(mk(0,0,0,8'h00, 0,0,0,0,8'h00, 0,1,0));
        tab.push_back(mk(0,0,0,8'h00, 0,0,0,0,8'h00, 0,1,0));
        run_tab("reset_a", 1'b0);
        tab.push_back(mk(0,0,0,8'h00, 0,0,0,0,8'h00, 0,1,0));
        run_tab("reset_b", 1'b1);

        // Basic replay, BLOCK_N=2.
        tab.push_back(mk(1,1,1,8'h01, 1,1,0,0,8'h01, 1,1,0));
        tab.push_back(mk(1,1,1,8'h02, 1,0,0,1,8'h01, 1,0,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,2,8'h01, 1,0,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,3,8'h01, 1,1,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,0,8'h02, 1,1,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,1,8'h02, 1,1,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,2,8'h02, 1,1,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,1,3,8'h02, 1,1,0));
        tab.push_back(mk(1,1,0,8'h00, 0,0,0,0,8'h00, 0,1,0));
        run_tab("basic", 1'b0);

        // Underrun on BLOCK_N=3, second word five cycles late.
        do_reset();
        tab.push_back(mk(1,1,1,8'h31, 1,1,0,0,8'h31, 1,1,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,1,8'h31, 1,1,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,2,8'h31, 1,1,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,3,8'h31, 1,1,0));
        for (int k = 0; k < 5; k++)
            tab.push_back(mk(1,1,0,8'h00, 0,0,0,0,8'h00, 1,1,1));
        tab.push_back(mk(1,1,1,8'h32, 1,0,0,0,8'h32, 1,1,1));
        tab.push_back(mk(1,1,1,8'h33, 1,0,0,1,8'h32, 1,0,1));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,2,8'h32, 1,0,1));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,3,8'h32, 1,1,1));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,0,8'h33, 1,1,1));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,1,8'h33, 1,1,1));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,2,8'h33, 1,1,1));
        tab.push_back(mk(1,1,0,8'h00, 1,0,1,3,8'h33, 1,1,1));
        tab.push_back(mk(1,1,0,8'h00, 0,0,0,0,8'h00, 0,1,1));
        run_tab("underrun", 1'b1);

        // Enable dropped mid-block; third word stays buffered.
        do_reset();
        tab.push_back(mk(1,1,1,8'h51, 1,1,0,0,8'h51, 1,1,0));
        tab.push_back(mk(1,0,1,8'h52, 1,0,0,1,8'h51, 1,0,0));
        tab.push_back(mk(1,0,0,8'h00, 1,0,0,2,8'h51, 1,0,0));
        tab.push_back(mk(1,0,0,8'h00, 1,0,0,3,8'h51, 1,1,0));
        tab.push_back(mk(1,0,1,8'h53, 1,0,0,0,8'h52, 1,0,0));
        tab.push_back(mk(1,0,0,8'h00, 1,0,0,1,8'h52, 1,0,0));
        tab.push_back(mk(1,0,0,8'h00, 1,0,0,2,8'h52, 1,0,0));
        tab.push_back(mk(1,0,0,8'h00, 1,0,1,3,8'h52, 1,0,0));
        tab.push_back(mk(1,0,0,8'h00, 0,0,0,0,8'h00, 0,0,0));
        tab.push_back(mk(1,0,0,8'h00, 0,0,0,0,8'h00, 0,0,0));
        tab.push_back(mk(1,0,0,8'h00, 0,0,0,0,8'h00, 0,0,0));
        tab.push_back(mk(1,1,0,8'h00, 1,1,0,0,8'h53, 1,1,0));
        run_tab("enable", 1'b0);

        // Reset at taddr 2 discards the block and the staged word.
        do_reset();
        tab.push_back(mk(1,1,1,8'h61, 1,1,0,0,8'h61, 1,1,0));
        tab.push_back(mk(1,1,1,8'h62, 1,0,0,1,8'h61, 1,0,0));
        tab.push_back(mk(1,1,0,8'h00, 1,0,0,2,8'h61, 1,0,0));
        tab.push_back(mk(0,1,0,8'h00, 0,0,0,0,8'h00, 0,1,0));
        tab.push_back(mk(1,1,0,8'h00, 0,0,0,0,8'h00, 0,1,0));
        tab.push_back(mk(1,1,0,8'h00, 0,0,0,0,8'h00, 0,1,0));
        run_tab("midreset", 1'b0);

        // Backpressure with three queued words, then back-to-back blocks.
        do_reset();
        w[0] = 8'h11;
        w[1] = 8'h22;
        w[2] = 8'h33;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 1'b1, idx < 3, idx < 3 ? w[idx] : 8'h00);
            if (hs) begin
                acc_cyc.push_back(c);
                idx++;
            end
            if (a_valid && a_taddr == 2'd0)
                seq.push_back(a_idata);
            if (c == 1)
                chk("bp_ready_low", {31'd0, a_ready}, 32'd0);
            if (c == 7)
                chk("b2b_last", {29'd0, a_valid, a_first, a_last}, 32'd5);
            if (c == 8)
                chk("b2b_first",
                    {21'd0, a_valid, a_first, a_last, a_idata},
                    {21'd0, 3'b110, 8'h33});
        end
        chk("bp_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("bp_acc0", acc_cyc[0], 0);
            chk("bp_acc1", acc_cyc[1], 1);
            chk("bp_acc2_at_wrap", acc_cyc[2], 4);
        end
        chk("bp_words", seq.size(), 3);
        if (seq.size() == 3)
            chk("bp_order", {8'd0, seq[0], seq[1], seq[2]},
                {8'd0, w[0], w[1], w[2]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
